alu_seq: RTL

Parametrised, handshaked successor to the 16-bit combinational ALU. It registers operands and results and produces status flags. It adds a multi-cycle unsigned multiply and valid/ready flow control on both sides. It sits between an operand source, such as a register file or test sequencer, and a result consumer that may apply backpressure.

---
 rtl/alu_seq_pkg.sv | 27 ++
 rtl/alu_seq_mul.sv | 72 +++++++
 rtl/alu_seq.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcode/state enums and flag bit positions for alu_seq
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLL = 3'b101,
        OP_SRL = 3'b110,
        OP_MUL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } alu_state_e;

    // Bit positions inside flags = {neg, zero, carry, ovf}
    localparam int FLAG_OVF   = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_ZERO  = 2;
    localparam int FLAG_NEG   = 3;

endpackage

// File: rtl/alu_seq_mul.sv
// rtl/alu_seq_mul.sv - shift-add unsigned multiplier (alu_mul_seq), one bit of b per cycle
module alu_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Next-state: the start edge already applies bit 0 of b, so together with
    // the WIDTH-1 busy steps exactly WIDTH shift-add steps are performed.
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        if (start) begin
            acc_d    = b[0] ? {{WIDTH{1'b0}}, a} : '0;
            mcand_d  = {{WIDTH{1'b0}}, a} << 1;
            mplier_d = b >> 1;
            cnt_d    = CNT_W'(1);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Multiplier state registers; reset discards any in-flight product
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign done = done_q;
    assign prod = acc_q;

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked registered ALU with optional multi-cycle MUL (ALU_SEQ_MUL_EN)
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       control,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] c_hi,
    output logic [3:0]       flags,
    output logic             illegal,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int SH_W = $clog2(WIDTH);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [WIDTH-1:0] c_hi_q, c_hi_d;
    logic [3:0]       flags_q, flags_d;
    logic             illegal_q, illegal_d;

    logic [WIDTH-1:0] alu_c;
    logic [3:0]       alu_flags;
    logic             alu_ill;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic             sh_big;

`ifdef ALU_SEQ_MUL_EN
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (a),
        .b     (b),
        .done  (mul_done),
        .prod  (mul_prod)
    );
`endif

    // Single-cycle datapath evaluated on the live operands while IDLE
    always_comb begin
        sum_ext   = {1'b0, a} + {1'b0, b};
        diff_ext  = {1'b0, a} - {1'b0, b};
        sh_big    = (b[WIDTH-1:SH_W] != '0);
        alu_c     = '0;
        alu_flags = '0;
        alu_ill   = 1'b0;
        case (alu_op_e'(control))
            OP_ADD: begin
                alu_c                = sum_ext[WIDTH-1:0];
                alu_flags[FLAG_CARRY] = sum_ext[WIDTH];
                alu_flags[FLAG_OVF]   = (a[WIDTH-1] == b[WIDTH-1]) &&
                                        (sum_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_c                = diff_ext[WIDTH-1:0];
                alu_flags[FLAG_CARRY] = diff_ext[WIDTH];
                alu_flags[FLAG_OVF]   = (a[WIDTH-1] != b[WIDTH-1]) &&
                                        (diff_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_c = a & b;
            OP_OR:  alu_c = a | b;
            OP_XOR: alu_c = a ^ b;
            OP_SLL: alu_c = sh_big ? '0 : (a << b[SH_W-1:0]);
            OP_SRL: alu_c = sh_big ? '0 : (a >> b[SH_W-1:0]);
            OP_MUL: begin
`ifndef ALU_SEQ_MUL_EN
                alu_ill = 1'b1;
`endif
            end
            default: alu_c = '0;
        endcase
        alu_flags[FLAG_NEG]  = alu_c[WIDTH-1];
        alu_flags[FLAG_ZERO] = (alu_c == '0);
        if (alu_ill) begin
            alu_flags = '0;
        end
    end

    // FSM next-state and result-register update
    always_comb begin
        state_d   = state_q;
        c_d       = c_q;
        c_hi_d    = c_hi_q;
        flags_d   = flags_q;
        illegal_d = illegal_q;
`ifdef ALU_SEQ_MUL_EN
        mul_start = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
`ifdef ALU_SEQ_MUL_EN
                    if (alu_op_e'(control) == OP_MUL) begin
                        mul_start = 1'b1;
                        state_d   = ST_EXEC;
                    end else begin
                        c_d       = alu_c;
                        c_hi_d    = '0;
                        flags_d   = alu_flags;
                        illegal_d = 1'b0;
                        state_d   = ST_DONE;
                    end
`else
                    c_d       = alu_c;
                    c_hi_d    = '0;
                    flags_d   = alu_flags;
                    illegal_d = alu_ill;
                    state_d   = ST_DONE;
`endif
                end
            end
            ST_EXEC: begin
`ifdef ALU_SEQ_MUL_EN
                if (mul_done) begin
                    c_d                = mul_prod[WIDTH-1:0];
                    c_hi_d             = mul_prod[2*WIDTH-1:WIDTH];
                    flags_d            = '0;
                    flags_d[FLAG_NEG]  = mul_prod[WIDTH-1];
                    flags_d[FLAG_ZERO] = (mul_prod[WIDTH-1:0] == '0);
                    flags_d[FLAG_OVF]  = (mul_prod[2*WIDTH-1:WIDTH] != '0);
                    illegal_d          = 1'b0;
                    state_d            = ST_DONE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            c_q       <= '0;
            c_hi_q    <= '0;
            flags_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            c_q       <= c_d;
            c_hi_q    <= c_hi_d;
            flags_q   <= flags_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign c         = c_q;
    assign c_hi      = c_hi_q;
    assign flags     = flags_q;
    assign illegal   = illegal_q;

endmodule
